// File: rtl/commit_checker.sv
// commit_checker: in-order checker of core writeback/store commits against a programmed table.
// Latency: a match/mismatch/timeout on edge N is reflected on all (registered) outputs after edge N.
// Backpressure: none; the checker only observes the core ports and never stalls them.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   tbl_we/idx/kind/addr/data  table programming (dropped while a run is active)
//   start, chk_count      begin a run over entries 0..chk_count-1
//   rf_we/rd/wd           core register writeback port
//   dm_we/addr/wd         core data-memory store port
//   busy/done/pass/fail   run status
//   fail_code/idx/data    first-failure report
//   match_cnt             entries matched so far
// Optional feature macro: CHECKER_MEM_EN (check kind=1 entries against the store port;
// when undefined, kind=1 entries auto-match in the cycle they become current).
module commit_checker #(
  parameter int XLEN           = 32,
  parameter int NUM_CHECKS     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tbl_we,
  input  logic [$clog2(NUM_CHECKS)-1:0] tbl_idx,
  input  logic                          tbl_kind,
  input  logic [XLEN-1:0]               tbl_addr,
  input  logic [XLEN-1:0]               tbl_data,
  input  logic                          start,
  input  logic [$clog2(NUM_CHECKS):0]   chk_count,
  input  logic                          rf_we,
  input  logic [4:0]                    rf_rd,
  input  logic [XLEN-1:0]               rf_wd,
  input  logic                          dm_we,
  input  logic [XLEN-1:0]               dm_addr,
  input  logic [XLEN-1:0]               dm_wd,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          fail,
  output logic [1:0]                    fail_code,
  output logic [$clog2(NUM_CHECKS)-1:0] fail_idx,
  output logic [XLEN-1:0]               fail_data,
  output logic [$clog2(NUM_CHECKS):0]   match_cnt
);
  localparam int IW = $clog2(NUM_CHECKS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [IW:0]     r_match_cnt, w_match_nxt;
  logic [IW:0]     r_count, w_count_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [1:0]      r_fail_code, w_code_nxt;
  logic [IW-1:0]   r_fail_idx, w_fidx_nxt;
  logic [XLEN-1:0] r_fail_data, w_fdata_nxt;
  logic            r_busy, r_done, r_pass, r_fail;

  // Expectation table: plain registers, deliberately not reset so a run can be repeated after rst.
  logic            r_tkind [NUM_CHECKS];
  logic [XLEN-1:0] r_taddr [NUM_CHECKS];
  logic [XLEN-1:0] r_tdata [NUM_CHECKS];

  always_ff @(posedge clk) begin
    if (tbl_we && (r_state != S_RUN)) begin
      r_tkind[tbl_idx] <= tbl_kind;
      r_taddr[tbl_idx] <= tbl_addr;
      r_tdata[tbl_idx] <= tbl_data;
    end
  end

  logic            w_e_kind;
  logic [XLEN-1:0] w_e_addr, w_e_data;
  assign w_e_kind = r_tkind[r_ptr];
  assign w_e_addr = r_taddr[r_ptr];
  assign w_e_data = r_tdata[r_ptr];

  // Only the port matching the current entry's kind is looked at, so at most one event per cycle.
  logic            w_evt;
  logic [XLEN-1:0] w_evt_data;
  always_comb begin
    w_evt      = 1'b0;
    w_evt_data = '0;
    if (!w_e_kind) begin
      w_evt      = rf_we && (rf_rd != 5'd0) && (rf_rd == w_e_addr[4:0]);
      w_evt_data = rf_wd;
    end else begin
`ifdef CHECKER_MEM_EN
      w_evt      = dm_we && (dm_addr == w_e_addr);
      w_evt_data = dm_wd;
`else
      // Store checking compiled out: the entry is taken as matched immediately.
      w_evt      = 1'b1;
      w_evt_data = w_e_data;
`endif
    end
  end

`ifndef CHECKER_MEM_EN
  logic w_unused_dm;
  assign w_unused_dm = ^{dm_we, dm_addr, dm_wd, w_e_addr[XLEN-1:5]};
`endif

  logic          w_bad_count;
  logic [IW:0]   w_match_inc;
  logic [TW-1:0] w_timer_inc;
  assign w_bad_count = (chk_count == '0) || (chk_count > (IW+1)'(NUM_CHECKS));
  assign w_match_inc = r_match_cnt + (IW+1)'(1);
  assign w_timer_inc = r_timer + TW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_match_nxt = r_match_cnt;
    w_count_nxt = r_count;
    w_timer_nxt = r_timer;
    w_code_nxt  = r_fail_code;
    w_fidx_nxt  = r_fail_idx;
    w_fdata_nxt = r_fail_data;
    case (r_state)
      S_RUN: begin
        if (w_evt && (w_evt_data == w_e_data)) begin
          w_ptr_nxt   = r_ptr + IW'(1);
          w_match_nxt = w_match_inc;
          w_timer_nxt = '0;
          if (w_match_inc == r_count) w_state_nxt = S_PASS;
        end else if (w_evt) begin
          w_state_nxt = S_FAIL;
          w_code_nxt  = 2'd1;
          w_fidx_nxt  = r_ptr;
          w_fdata_nxt = w_evt_data;
        end else begin
          w_timer_nxt = w_timer_inc;
          if (w_timer_inc == TW'(TIMEOUT_CYCLES)) begin
            w_state_nxt = S_FAIL;
            w_code_nxt  = 2'd2;
            w_fidx_nxt  = r_ptr;
          end
        end
      end
      default: begin
        if (start) begin
          w_ptr_nxt   = '0;
          w_match_nxt = '0;
          w_timer_nxt = '0;
          w_fidx_nxt  = '0;
          w_fdata_nxt = '0;
          w_count_nxt = chk_count;
          if (w_bad_count) begin
            w_state_nxt = S_FAIL;
            w_code_nxt  = 2'd3;
          end else begin
            w_state_nxt = S_RUN;
            w_code_nxt  = 2'd0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_match_cnt <= '0;
      r_count     <= '0;
      r_timer     <= '0;
      r_fail_code <= '0;
      r_fail_idx  <= '0;
      r_fail_data <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_match_cnt <= w_match_nxt;
      r_count     <= w_count_nxt;
      r_timer     <= w_timer_nxt;
      r_fail_code <= w_code_nxt;
      r_fail_idx  <= w_fidx_nxt;
      r_fail_data <= w_fdata_nxt;
      // Status flags are flopped from the next state so the outputs are pure register outputs.
      r_busy      <= (w_state_nxt == S_RUN);
      r_done      <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL);
      r_pass      <= (w_state_nxt == S_PASS);
      r_fail      <= (w_state_nxt == S_FAIL);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign fail_code = r_fail_code;
  assign fail_idx  = r_fail_idx;
  assign fail_data = r_fail_data;
  assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_commit_checker.sv
// Bench for commit_checker: directed scenarios plus randomized runs, all outputs compared every cycle
// against a behavioural model of the checker's rules, with literal expectations on key scenarios.
module tb_commit_checker;
  localparam int NC  = 8;
  localparam int TMO = 16;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PASS = 2, ST_FAIL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        tbl_we;
  logic [2:0]  tbl_idx;
  logic        tbl_kind;
  logic [31:0] tbl_addr, tbl_data;
  logic        start;
  logic [3:0]  chk_count;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wd;
  logic        busy, done, pass, fail;
  logic [1:0]  fail_code;
  logic [2:0]  fail_idx;
  logic [31:0] fail_data;
  logic [3:0]  match_cnt;

  int n_checks = 0;
  int n_errors = 0;

  commit_checker #(.XLEN(32), .NUM_CHECKS(NC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_kind(tbl_kind), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .start(start), .chk_count(chk_count),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_code(fail_code), .fail_idx(fail_idx), .fail_data(fail_data), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_kind [NC];
  int m_addr [NC];
  int m_data [NC];
  int m_state = ST_IDLE;
  int m_ptr = 0, m_match = 0, m_count = 0, m_idle = 0;
  int m_code = 0, m_fidx = 0;
  logic [31:0] m_fdata = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = ST_IDLE; m_ptr = 0; m_match = 0; m_idle = 0;
      m_code = 0; m_fidx = 0; m_fdata = 0;
    end else if (m_state == ST_RUN) begin
      bit hit;
      logic [31:0] seen;
      hit  = 0;
      seen = 0;
      if (m_kind[m_ptr] == 0) begin
        if (rf_we && rf_rd != 0 && int'(rf_rd) == (m_addr[m_ptr] % 32)) begin hit = 1; seen = rf_wd; end
      end else begin
`ifdef CHECKER_MEM_EN
        if (dm_we && dm_addr == m_addr[m_ptr]) begin hit = 1; seen = dm_wd; end
`else
        hit = 1; seen = m_data[m_ptr];
`endif
      end
      if (hit && seen == m_data[m_ptr]) begin
        m_ptr++; m_match++; m_idle = 0;
        if (m_match == m_count) m_state = ST_PASS;
      end else if (hit) begin
        m_state = ST_FAIL; m_code = 1; m_fidx = m_ptr; m_fdata = seen;
      end else begin
        m_idle++;
        if (m_idle == TMO) begin m_state = ST_FAIL; m_code = 2; m_fidx = m_ptr; end
      end
    end else begin
      if (tbl_we) begin
        m_kind[tbl_idx] = tbl_kind; m_addr[tbl_idx] = tbl_addr; m_data[tbl_idx] = tbl_data;
      end
      if (start) begin
        m_ptr = 0; m_match = 0; m_idle = 0; m_fidx = 0; m_fdata = 0; m_count = chk_count;
        if (chk_count == 0 || chk_count > NC) begin m_state = ST_FAIL; m_code = 3; end
        else begin m_state = ST_RUN; m_code = 0; end
      end
    end
  end

  // Compare every cycle, just after the active edge.
  always @(posedge clk) begin
    #1;
    chk("busy",      busy,      m_state == ST_RUN);
    chk("done",      done,      m_state == ST_PASS || m_state == ST_FAIL);
    chk("pass",      pass,      m_state == ST_PASS);
    chk("fail",      fail,      m_state == ST_FAIL);
    chk("fail_code", fail_code, m_code);
    chk("fail_idx",  fail_idx,  m_fidx);
    chk("fail_data", fail_data, m_fdata);
    chk("match_cnt", match_cnt, m_match);
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    tbl_we = 0; tbl_idx = 0; tbl_kind = 0; tbl_addr = 0; tbl_data = 0;
    start = 0; chk_count = 0;
    rf_we = 0; rf_rd = 0; rf_wd = 0; dm_we = 0; dm_addr = 0; dm_wd = 0;
  endtask

  task automatic write_entry(input int idx, input int kind, input int addr, input int data);
    tbl_we = 1; tbl_idx = 3'(idx); tbl_kind = kind[0]; tbl_addr = addr; tbl_data = data;
    @(negedge clk);
    tbl_we = 0;
  endtask

  task automatic do_start(input int cnt);
    start = 1; chk_count = 4'(cnt);
    @(negedge clk);
    start = 0;
  endtask

  task automatic rf_write(input int rd, input int wd);
    rf_we = 1; rf_rd = 5'(rd); rf_wd = wd;
    @(negedge clk);
    rf_we = 0; rf_rd = 0; rf_wd = 0;
  endtask

  task automatic rand_run();
    int cnt, sel, bnd;
    for (int i = 0; i < NC; i++) begin
      int k;
      k = $urandom_range(0, 1);
      write_entry(i, k, k ? 4 * $urandom_range(0, 3) : $urandom_range(1, 7), $urandom_range(0, 3));
    end
    sel = $urandom_range(0, 11);
    cnt = (sel == 0) ? 0 : (sel == 1) ? 9 : $urandom_range(1, NC);
    do_start(cnt);
    bnd = 0;
    while (m_state == ST_RUN && bnd < 200) begin
      sel = $urandom_range(0, 9);
      clear_inputs();
      if (sel < 6 || sel == 6) begin
        logic [31:0] d;
        d = (sel == 6) ? 32'(m_data[m_ptr] ^ 1) : 32'(m_data[m_ptr]);
        if (m_kind[m_ptr] == 0) begin rf_we = 1; rf_rd = 5'(m_addr[m_ptr]); rf_wd = d; end
        else begin dm_we = 1; dm_addr = m_addr[m_ptr]; dm_wd = d; end
      end else if (sel == 7) begin
        rf_we = 1; rf_rd = 5'($urandom_range(0, 7)); rf_wd = $urandom_range(0, 3);
        dm_we = 1; dm_addr = 4 * $urandom_range(0, 3); dm_wd = $urandom_range(0, 3);
      end else if (sel == 8) begin
        dm_we = 1; dm_addr = 4 * $urandom_range(0, 3); dm_wd = $urandom_range(0, 3);
      end else begin
        // start and table writes during a run must have no effect
        start = 1; chk_count = 4'($urandom_range(0, 9));
        tbl_we = 1; tbl_idx = 3'($urandom_range(0, 7)); tbl_kind = 1'($urandom_range(0, 1));
        tbl_addr = $urandom_range(0, 15); tbl_data = $urandom_range(0, 3);
      end
      @(negedge clk);
      bnd++;
    end
    clear_inputs();
    if (m_state == ST_RUN) chk("rand_run_bound", 0, 1);
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cyc;
    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_match_cnt", match_cnt, 0);
    chk("reset_fail_code", fail_code, 0);
    rst = 0;
    @(negedge clk);

    // Reset in mid-run, then rerun on the retained table (also the register sequence scenario).
    write_entry(0, 0, 7, 32'h20);
    write_entry(1, 0, 5, 32'h9);
    do_start(2);
    repeat (3) @(negedge clk);
    chk("midrun_busy", busy, 1);
    rst = 1;
    #1;
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_match", match_cnt, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    do_start(2);
    rf_write(7, 32'h20);
    chk("seq_match1", match_cnt, 1);
    rf_write(3, 32'h1);
    chk("seq_ignored_busy", busy, 1);
    rf_write(5, 32'h9);
    chk("seq_pass", pass, 1);
    chk("seq_code", fail_code, 0);
    chk("seq_match2", match_cnt, 2);

    // Data mismatch on the second entry.
    do_start(2);
    rf_write(7, 32'h20);
    rf_write(5, 32'h8);
    chk("mm_fail", fail, 1);
    chk("mm_code", fail_code, 1);
    chk("mm_idx", fail_idx, 1);
    chk("mm_data", fail_data, 32'h8);

    // Store entry.
    write_entry(0, 1, 12, 32'h9);
    do_start(1);
`ifdef CHECKER_MEM_EN
    @(negedge clk);
    chk("store_wait_busy", busy, 1);
    dm_we = 1; dm_addr = 12; dm_wd = 32'h9;
    @(negedge clk);
    clear_inputs();
    chk("store_pass", pass, 1);
`else
    @(negedge clk);
    chk("store_auto_pass", pass, 1);
    chk("store_auto_match", match_cnt, 1);
`endif

    // Timeout with x0 and wrong-destination writes carrying the expected data.
    write_entry(0, 0, 7, 32'h55);
    do_start(1);
    cyc = 0;
    while (!done && cyc < 40) begin
      if (cyc < 3) begin rf_we = 1; rf_rd = 0; rf_wd = 32'h55; end
      else if (cyc < 6) begin rf_we = 1; rf_rd = 9; rf_wd = 32'h55; end
      else begin rf_we = 0; rf_rd = 0; rf_wd = 0; end
      @(negedge clk);
      cyc++;
    end
    clear_inputs();
    chk("tmo_cycles", cyc, TMO);
    chk("tmo_code", fail_code, 2);
    chk("tmo_idx", fail_idx, 0);

    // Bad chk_count values.
    do_start(0);
    chk("bad0_code", fail_code, 3);
    chk("bad0_busy", busy, 0);
    chk("bad0_fail", fail, 1);
    do_start(NC + 1);
    chk("bad9_code", fail_code, 3);
    chk("bad9_busy", busy, 0);
    chk("bad9_idx", fail_idx, 0);

    // Randomized runs.
    for (int r = 0; r < 60; r++) rand_run();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/commit_checker.md
# commit_checker

Synthesizable, parametrised commit-stream checker that sits beside the single-cycle core top and watches its register-file writeback and data-memory store ports. It checks them in order against a programmed table of up to NUM_CHECKS expected results. It replaces fixed-delay `$display` checking with a pass/fail state machine that has a timeout and reports the first failure, so the same checks run in simulation and on hardware.

## Interface
- XLEN, 32: data and address width of the checked ports.
- NUM_CHECKS, 8: table depth, ≥2. Index width is IW = $clog2(NUM_CHECKS).
- TIMEOUT_CYCLES, 1024: idle cycles allowed between matches before the checker fails. Counter width is $clog2(TIMEOUT_CYCLES+1).

- clk  in  1  single clock; everything is sampled on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- tbl_we  in  1  table write strobe; accepted only in IDLE/PASS/FAIL.
- tbl_idx  in  IW  table entry written.
- tbl_kind  in  1  entry kind: 0 = register writeback, 1 = memory store.
- tbl_addr  in  XLEN  expected rd (bits [4:0] only) or store address.
- tbl_data  in  XLEN  expected data.
- start  in  1  pulse; begins a run.
- chk_count  in  IW+1  number of entries to check; latched at start.
- rf_we, rf_rd[4:0], rf_wd[XLEN-1:0]  in  core writeback port.
- dm_we, dm_addr[XLEN-1:0], dm_wd[XLEN-1:0]  in  core store port.
- busy  out  1  high in RUN.
- done  out  1  high in PASS or FAIL.
- pass  out  1  high in PASS.
- fail  out  1  high in FAIL.
- fail_code  out  2  0 none, 1 data mismatch, 2 timeout, 3 bad chk_count.
- fail_idx  out  IW  table index being checked when the failure occurred.
- fail_data  out  XLEN  observed data on a mismatch, otherwise 0.
- match_cnt  out  IW+1  entries matched so far.

## Operation
- FSM states: IDLE, RUN, PASS, FAIL.
  - IDLE, PASS and FAIL go to RUN on start.
  - RUN goes to PASS or FAIL.
  - start while in RUN is ignored.
- Table: NUM_CHECKS entries of {kind, addr, data}, held in registers. Reset does not clear it. Writes while in RUN are dropped.
- On start:
  - chk_count==0 or chk_count>NUM_CHECKS: go to FAIL with code 3 and fail_idx=0.
  - Otherwise: clear ptr, match_cnt, timer and the fail_* outputs, then go to RUN.
- In RUN, the current entry is E=table[ptr]. Checks are strictly in order.
  - Register event: rf_we && rf_rd!=0 && E.kind==0 && rf_rd==E.addr[4:0].
  - Memory event: dm_we && E.kind==1 && dm_addr==E.addr.
  - If the event's data equals E.data, the entry matches: ptr++, match_cnt++, timer cleared.
  - If the event's data differs: go to FAIL, code 1, fail_idx=ptr, fail_data=observed data.
  - Writes to any other destination, and writes to x0, are ignored.
- Register and memory events in the same cycle: only the event of the current entry's kind is evaluated. At most one entry advances per cycle.
- When match_cnt reaches the latched count: go to PASS.
- Timer: increments every RUN cycle without a match. When it reaches TIMEOUT_CYCLES: go to FAIL, code 2, fail_idx=ptr.
- Reset during a run: returns to IDLE immediately. The table is kept.

## Timing
- Reset values: busy=0, done=0, pass=0, fail=0, fail_code=0, fail_idx=0, fail_data=0, match_cnt=0. State is IDLE.
- All outputs are registered.
- Latency:
  - A match on edge N is visible in match_cnt after edge N.
  - PASS/FAIL is entered on the same edge as the final match or the mismatch, so done is high after that edge.
  - busy is high the cycle after start.
- Table writes take effect on the edge that samples tbl_we. A write and a start on the same edge: the write is applied and the run uses the new entry.
- Timeout fires on the TIMEOUT_CYCLES-th consecutive non-matching RUN cycle.

## Configuration
- CHECKER_MEM_EN defined: kind=1 entries are checked against the dm_* store port as described above.
- CHECKER_MEM_EN undefined:
  - The dm_* inputs are ignored.
  - A kind=1 entry counts as matched in the cycle it becomes current: one cycle per entry, timer cleared.
  - A run whose entries are all kind=1 therefore passes after chk_count cycles.

## Test plan
- Reset mid-run: program 2 entries, start, assert rst after 3 cycles -> all outputs 0, IDLE; start again -> table unchanged, run proceeds.
- Register sequence: table {0: reg x7 = 0x20, 1: reg x5 = 0x9}, chk_count=2; drive rf writes x7=0x20, then x3=0x1 (ignored), then x5=0x9 -> pass=1, fail_code=0, match_cnt=2, the cycle after the x5 write.
- Mismatch: same table; drive x7=0x20, then x5=0x8 -> fail=1, fail_code=1, fail_idx=1, fail_data=0x8.
- Store check (CHECKER_MEM_EN): entry {mem addr 12 = 0x9}; a dm write of addr 12, data 0x9 -> pass. Without the macro -> pass one cycle after start with no dm activity.
- Timeout: TIMEOUT_CYCLES=16, one entry, no matching writes -> fail_code=2 after exactly 16 RUN cycles; a write to x0 with the expected data does not match.
- Bad configuration: start with chk_count=0 -> fail_code=3, busy never asserted. Start with chk_count=NUM_CHECKS+1 -> same result.
